// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences ecall/mret trap side effects onto the single CSR write port and issues a PC redirect.
// Optional interrupt entry is built in when TRAP_CTRL_IRQ_EN is defined.
module trap_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = DATA_WIDTH'(32'hb)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_ecall,
  input  logic                  req_mret,
  input  logic [DATA_WIDTH-1:0] req_pc,
  output logic [ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_wen,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
`ifdef TRAP_CTRL_IRQ_EN
  input  logic                  irq,
  input  logic [DATA_WIDTH-1:0] irq_pc,
`endif
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] CSR_MSTATUS = ADDR_WIDTH'(12'h300);
  localparam logic [ADDR_WIDTH-1:0] CSR_MTVEC   = ADDR_WIDTH'(12'h305);
  localparam logic [ADDR_WIDTH-1:0] CSR_MEPC    = ADDR_WIDTH'(12'h341);
  localparam logic [ADDR_WIDTH-1:0] CSR_MCAUSE  = ADDR_WIDTH'(12'h342);
  localparam logic [DATA_WIDTH-1:0] IRQ_CAUSE   = {1'b1, {(DATA_WIDTH-5){1'b0}}, 4'hb};
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_STAT  = 3'd3,
    S_M_STAT  = 3'd4,
    S_REDIR   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] mstat_q, mstat_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  irq_cause_q, irq_cause_d;
  logic                  irq_take_s;
  logic [DATA_WIDTH-1:0] irq_pc_s;

  function automatic logic [DATA_WIDTH-1:0] trap_mstatus(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r           = s;
    r[MPIE_BIT] = s[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    r[12:11]    = 2'b11;
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mret_mstatus(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r           = s;
    r[MIE_BIT]  = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    r[12:11]    = 2'b11;
    return r;
  endfunction

`ifdef TRAP_CTRL_IRQ_EN
  // In IDLE csr_raddr points at mstatus, so csr_rdata carries the live MIE bit.
  assign irq_take_s = (state_q == S_IDLE) & irq & ~req_valid & csr_rdata[MIE_BIT];
  assign irq_pc_s   = irq_pc;
`else
  assign irq_take_s = 1'b0;
  assign irq_pc_s   = {DATA_WIDTH{1'b0}};
`endif

  // State and latched trap context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= {DATA_WIDTH{1'b0}};
      mstat_q     <= {DATA_WIDTH{1'b0}};
      target_q    <= {DATA_WIDTH{1'b0}};
      irq_cause_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mstat_q     <= mstat_d;
      target_q    <= target_d;
      irq_cause_q <= irq_cause_d;
    end
  end

  // Next-state and context capture.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mstat_d     = mstat_q;
    target_d    = target_q;
    irq_cause_d = irq_cause_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          pc_d        = req_pc;
          mstat_d     = csr_rdata;
          irq_cause_d = 1'b0;
          if (req_ecall) begin
            state_d = S_T_EPC;
          end else if (req_mret) begin
            state_d = S_M_STAT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (irq_take_s) begin
          pc_d        = irq_pc_s;
          irq_cause_d = 1'b1;
          state_d     = S_T_EPC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T_EPC: begin
        mstat_d = csr_rdata;
        state_d = S_T_CAUSE;
      end
      S_T_CAUSE: state_d = S_T_STAT;
      S_T_STAT: begin
        target_d = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
        state_d  = S_REDIR;
      end
      S_M_STAT: begin
        target_d = csr_rdata;
        state_d  = S_REDIR;
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched context only.
  always_comb begin
    req_ready      = 1'b0;
    busy           = 1'b1;
    csr_raddr      = CSR_MSTATUS;
    csr_wen        = 1'b0;
    csr_waddr      = {ADDR_WIDTH{1'b0}};
    csr_wdata      = {DATA_WIDTH{1'b0}};
    redirect_valid = 1'b0;
    redirect_pc    = {DATA_WIDTH{1'b0}};
    case (state_q)
      S_IDLE: begin
        req_ready = ~irq_take_s;
        busy      = 1'b0;
      end
      S_T_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = pc_q;
      end
      S_T_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = irq_cause_q ? IRQ_CAUSE : ECALL_CAUSE;
      end
      S_T_STAT: begin
        csr_raddr = CSR_MTVEC;
        csr_wen   = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = trap_mstatus(mstat_q);
      end
      S_M_STAT: begin
        csr_raddr = CSR_MEPC;
        csr_wen   = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mret_mstatus(mstat_q);
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed plan scenarios plus randomized requests
// checked cycle by cycle against a transaction-level model and a small CSR file.
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_ecall;
  logic        req_mret;
  logic [31:0] req_pc;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
`ifdef TRAP_CTRL_IRQ_EN
  logic        irq;
  logic [31:0] irq_pc;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // CSR file model: combinational read, write on clock edge, plus a backdoor preload.
  logic [31:0] f_mstatus, f_mtvec, f_mepc, f_mcause;
  logic        ld_en;
  logic [31:0] ld_mstatus, ld_mtvec, ld_mepc, ld_mcause;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ecall(req_ecall), .req_mret(req_mret), .req_pc(req_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef TRAP_CTRL_IRQ_EN
    .irq(irq), .irq_pc(irq_pc),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (csr_raddr)
      12'h300: csr_rdata = f_mstatus;
      12'h305: csr_rdata = f_mtvec;
      12'h341: csr_rdata = f_mepc;
      12'h342: csr_rdata = f_mcause;
      default: csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (ld_en) begin
      f_mstatus <= ld_mstatus;
      f_mtvec   <= ld_mtvec;
      f_mepc    <= ld_mepc;
      f_mcause  <= ld_mcause;
    end else if (csr_wen) begin
      case (csr_waddr)
        12'h300: f_mstatus <= csr_wdata;
        12'h305: f_mtvec   <= csr_wdata;
        12'h341: f_mepc    <= csr_wdata;
        12'h342: f_mcause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  // Architectural mstatus updates, written as plain bit arithmetic.
  function automatic logic [31:0] m_trap(input logic [31:0] m);
    return (m & ~32'h0000_0088) | ((m & 32'h0000_0008) << 4) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] m_mret(input logic [31:0] m);
    return (m & ~32'h0000_0088) | ((m >> 4) & 32'h0000_0008) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] m, input logic [31:0] tv, input logic [31:0] e, input logic [31:0] c);
    ld_mstatus = m; ld_mtvec = tv; ld_mepc = e; ld_mcause = c;
    ld_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issue one request (or interrupt) at a negedge and check every cycle up to the return to idle.
  task automatic run_txn(input string name, input logic ec, input logic mr, input logic irqv,
                         input logic [31:0] pc, input logic keep);
    logic [31:0] m0, tv, e0, c0, cause, epc;
    logic        trap, mret_path;
    int          n;
    logic        e_wen, e_rv, e_idle;
    logic [11:0] e_wa;
    logic [31:0] e_wd, e_rpc;
    m0 = f_mstatus; tv = f_mtvec; e0 = f_mepc; c0 = f_mcause;
    trap      = irqv ? m0[3] : ec;
    mret_path = !irqv && !ec && mr;
    cause     = irqv ? 32'h8000_000B : 32'h0000_000B;
    epc       = pc;
    n         = trap ? 4 : (mret_path ? 2 : 0);
    req_valid = !irqv;
    req_ecall = ec;
    req_mret  = mr;
    req_pc    = irqv ? 32'hDEAD_BEE0 : pc;
`ifdef TRAP_CTRL_IRQ_EN
    irq    = irqv;
    irq_pc = pc;
`endif
    #1;
    chk({name, " pre ready"}, 32'(req_ready), 32'(!(irqv && m0[3])));
    chk({name, " pre busy"}, 32'(busy), 32'h0);
    @(posedge clk);
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) begin
        req_valid = 1'b0;
`ifdef TRAP_CTRL_IRQ_EN
        irq = 1'b0;
`endif
      end
      e_wen = 1'b0; e_wa = 12'h0; e_wd = 32'h0; e_rv = 1'b0; e_rpc = 32'h0;
      if (trap) begin
        if (k == 1) begin e_wen = 1'b1; e_wa = 12'h341; e_wd = epc; end
        else if (k == 2) begin e_wen = 1'b1; e_wa = 12'h342; e_wd = cause; end
        else if (k == 3) begin e_wen = 1'b1; e_wa = 12'h300; e_wd = m_trap(m0); end
        else if (k == 4) begin e_rv = 1'b1; e_rpc = tv & 32'hFFFF_FFFC; end
      end else if (mret_path) begin
        if (k == 1) begin e_wen = 1'b1; e_wa = 12'h300; e_wd = m_mret(m0); end
        else if (k == 2) begin e_rv = 1'b1; e_rpc = e0; end
      end
      e_idle = (k == n + 1);
      chk($sformatf("%s c%0d wen", name, k), 32'(csr_wen), 32'(e_wen));
      chk($sformatf("%s c%0d waddr", name, k), 32'(csr_waddr), 32'(e_wa));
      chk($sformatf("%s c%0d wdata", name, k), csr_wdata, e_wd);
      chk($sformatf("%s c%0d redir_v", name, k), 32'(redirect_valid), 32'(e_rv));
      chk($sformatf("%s c%0d redir_pc", name, k), redirect_pc, e_rpc);
      chk($sformatf("%s c%0d busy", name, k), 32'(busy), 32'(!e_idle));
      chk($sformatf("%s c%0d ready", name, k), 32'(req_ready), 32'(e_idle));
    end
    chk({name, " f_mepc"}, f_mepc, trap ? epc : e0);
    chk({name, " f_mcause"}, f_mcause, trap ? cause : c0);
    chk({name, " f_mstatus"}, f_mstatus, trap ? m_trap(m0) : (mret_path ? m_mret(m0) : m0));
  endtask

  initial begin
    logic [31:0] rpc;
    logic [1:0]  kind;
    rst = 1'b1;
    req_valid = 1'b0; req_ecall = 1'b0; req_mret = 1'b0; req_pc = 32'h0;
    ld_en = 1'b0; ld_mstatus = 32'h0; ld_mtvec = 32'h0; ld_mepc = 32'h0; ld_mcause = 32'h0;
    f_mstatus = 32'h0; f_mtvec = 32'h0; f_mepc = 32'h0; f_mcause = 32'h0;
`ifdef TRAP_CTRL_IRQ_EN
    irq = 1'b0; irq_pc = 32'h0;
`endif
    #2;
    chk("rst ready", 32'(req_ready), 32'h1);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst wen", 32'(csr_wen), 32'h0);
    chk("rst raddr", 32'(csr_raddr), 32'h300);
    chk("rst redir_v", 32'(redirect_valid), 32'h0);
    chk("rst redir_pc", redirect_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    preload(32'h0000_1808, 32'h8000_0100, 32'h0, 32'h0);
    run_txn("ecall", 1'b1, 1'b0, 1'b0, 32'h8000_0010, 1'b0);
    preload(32'h0000_1880, 32'h8000_0100, 32'h8000_0014, 32'h0000_000B);
    run_txn("mret", 1'b0, 1'b1, 1'b0, 32'h8000_0400, 1'b0);
    preload(32'h0000_1808, 32'h8000_0103, 32'h0, 32'h0);
    run_txn("align", 1'b1, 1'b0, 1'b0, 32'h8000_0020, 1'b0);
    preload(32'h0000_0008, 32'h8000_0200, 32'h8000_0044, 32'h0);
    run_txn("both", 1'b1, 1'b1, 1'b0, 32'h8000_0030, 1'b0);
    run_txn("none", 1'b0, 1'b0, 1'b0, 32'h8000_0034, 1'b0);

    // Request held high across a busy sequence: the next accept is exactly one cycle after the redirect.
    preload(32'h0000_1808, 32'h8000_0100, 32'h0, 32'h0);
    run_txn("held1", 1'b1, 1'b0, 1'b0, 32'h8000_0050, 1'b1);
    run_txn("held2", 1'b1, 1'b0, 1'b0, 32'h8000_0054, 1'b0);

    // Reset during T_CAUSE aborts; the mepc write already landed.
    preload(32'h0000_1808, 32'h8000_0100, 32'h1111_1111, 32'h2222_2222);
    req_valid = 1'b1; req_ecall = 1'b1; req_mret = 1'b0; req_pc = 32'h8000_0060;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort pre wen", 32'(csr_wen), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort wen", 32'(csr_wen), 32'h0);
    chk("abort waddr", 32'(csr_waddr), 32'h0);
    chk("abort wdata", csr_wdata, 32'h0);
    chk("abort ready", 32'(req_ready), 32'h1);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort raddr", 32'(csr_raddr), 32'h300);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort c%0d redir_v", k), 32'(redirect_valid), 32'h0);
      chk($sformatf("abort c%0d busy", k), 32'(busy), 32'h0);
    end
    chk("abort f_mepc", f_mepc, 32'h8000_0060);
    chk("abort f_mcause", f_mcause, 32'h2222_2222);

`ifdef TRAP_CTRL_IRQ_EN
    preload(32'h0000_1808, 32'h8000_0100, 32'h0, 32'h0);
    run_txn("irq", 1'b0, 1'b0, 1'b1, 32'h8000_0200, 1'b0);
    preload(32'h0000_1800, 32'h8000_0100, 32'h3333_3333, 32'h4444_4444);
    run_txn("irq_masked", 1'b0, 1'b0, 1'b1, 32'h8000_0200, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      preload($urandom, $urandom, $urandom, $urandom);
      rpc  = $urandom;
      kind = 2'($urandom_range(0, 3));
      run_txn($sformatf("rnd%0d", i), kind[0], kind[1], 1'b0, rpc, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
